// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU package: fetch FSM encoding and PC constants.
// Imported by the fetch controller and its bench.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Force a target onto a word boundary.
    function automatic logic [31:0] word_align(
        input logic [31:0] pc
    );
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: loader port, PC sequencing
// and a one-entry valid/ready output towards decode.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic        i_halt,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_load_valid,
    input  logic [31:0] i_load_addr,
    input  logic [31:0] i_load_data,
    output logic        o_load_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_dec_valid,
    input  logic        i_dec_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic [1:0]  o_state,
    output logic [31:0] o_fetch_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic [31:0]  out_inst_q, out_inst_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  cnt_q, cnt_d;

    logic accept;
    logic slot_free;
    logic in_idle;

    assign accept    = out_valid_q & i_dec_ready;
    assign slot_free = ~out_valid_q | i_dec_ready;
    assign in_idle   = (state_q == ST_IDLE);

    // Memory port: loader owns it in IDLE, fetch PC otherwise.
    always_comb begin
        o_load_ready = in_idle;
        o_mem_we     = 1'b0;
        o_mem_addr   = pc_q;
        o_mem_wdata  = 32'd0;
        if (in_idle) begin
            o_mem_we    = i_load_valid;
            o_mem_addr  = i_load_addr;
            o_mem_wdata = i_load_data;
        end
    end

    // Next-state, PC and output-slot update.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_valid_d = out_valid_q;
        cnt_d       = accept ? cnt_q + 32'd1 : cnt_q;

        // An accepted entry leaves the slot unless refilled below.
        if (accept) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                // A coinciding load wins; start waits a cycle.
                if (i_start && !i_load_valid) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (i_redirect) begin
                    pc_d        = word_align(i_redirect_pc);
                    out_valid_d = 1'b0;
                end else begin
                    if (slot_free) begin
                        out_pc_d    = pc_q;
                        out_inst_d  = i_mem_rdata;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + PC_STEP;
                    end
                    if (i_halt) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (i_redirect) begin
                    pc_d        = word_align(i_redirect_pc);
                    out_valid_d = 1'b0;
                end
                if (i_start && !i_halt) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with async active-low reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            out_pc_q    <= 32'd0;
            out_inst_q  <= 32'd0;
            out_valid_q <= 1'b0;
            cnt_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_dec_valid = out_valid_q;
    assign o_pc        = out_pc_q;
    assign o_inst      = out_inst_q;
    assign o_state     = state_q;
    assign o_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an external
// combinational-read instruction memory model.
module tb_fetch_ctrl;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        load_valid;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  state;
    logic [31:0] fetch_cnt;

    logic [31:0] mem [256];

    int tests;
    int fails;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_start       (start),
        .i_halt        (halt),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_load_valid  (load_valid),
        .i_load_addr   (load_addr),
        .i_load_data   (load_data),
        .o_load_ready  (load_ready),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .o_dec_valid   (dec_valid),
        .i_dec_ready   (dec_ready),
        .o_pc          (pc),
        .o_inst        (inst),
        .o_state       (state),
        .o_fetch_cnt   (fetch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
        tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
        tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", dec_valid); end
        tests++; if (fetch_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", fetch_cnt); end
        tests++; if (pc !== 32'd0 || inst !== 32'd0) begin fails++; $display("FAIL reset_out got pc=%h inst=%h want 0/0", pc, inst); end
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_load();
        logic [31:0] words [3];
        words[0] = 32'h13;
        words[1] = 32'h93;
        words[2] = 32'h113;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_addr  = 32'(i * 4);
            load_data  = words[i];
            start      = (i == 2);
            #1;
            tests++; if (mem_we !== 1'b1 || load_ready !== 1'b1) begin fails++; $display("FAIL load_we[%0d] got we=%b rdy=%b want 1/1", i, mem_we, load_ready); end
            tests++; if (mem_addr !== 32'(i * 4) || mem_wdata !== words[i]) begin fails++; $display("FAIL load_bus[%0d] got %h/%h want %h/%h", i, mem_addr, mem_wdata, i * 4, words[i]); end
            step();
        end
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL load_wins_start got state %0d want 0", state); end
        tests++; if (mem[2] !== 32'h113) begin fails++; $display("FAIL load_mem2 got %h want 113", mem[2]); end
        load_valid = 1'b0;
    endtask

    task automatic test_fetch();
        start = 1'b1;
        dec_ready = 1'b1;
        step();
        start = 1'b0;
        tests++; if (state !== 2'd1 || dec_valid !== 1'b0) begin fails++; $display("FAIL start got state=%0d valid=%b want 1/0", state, dec_valid); end
        tests++; if (load_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0) begin fails++; $display("FAIL run_port got rdy=%b we=%b addr=%h want 0/0/0", load_ready, mem_we, mem_addr); end
        step();
        tests++; if (dec_valid !== 1'b1 || pc !== 32'd0 || inst !== 32'h13) begin fails++; $display("FAIL fetch0 got v=%b pc=%h inst=%h want 1/0/13", dec_valid, pc, inst); end
        step();
        tests++; if (pc !== 32'd4 || inst !== 32'h93 || fetch_cnt !== 32'd1) begin fails++; $display("FAIL fetch1 got pc=%h inst=%h cnt=%0d want 4/93/1", pc, inst, fetch_cnt); end
        step();
        tests++; if (pc !== 32'd8 || inst !== 32'h113 || fetch_cnt !== 32'd2) begin fails++; $display("FAIL fetch2 got pc=%h inst=%h cnt=%0d want 8/113/2", pc, inst, fetch_cnt); end
        step();
        tests++; if (fetch_cnt !== 32'd3 || pc !== 32'hC) begin fails++; $display("FAIL fetch_cnt got cnt=%0d pc=%h want 3/c", fetch_cnt, pc); end
    endtask

    task automatic test_backpressure();
        redirect = 1'b1;
        redirect_pc = 32'd4;
        step();
        redirect = 1'b0;
        tests++; if (dec_valid !== 1'b0 || fetch_cnt !== 32'd4) begin fails++; $display("FAIL bp_redirect got v=%b cnt=%0d want 0/4", dec_valid, fetch_cnt); end
        step();
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (dec_valid !== 1'b1 || pc !== 32'd4 || inst !== 32'h93) begin fails++; $display("FAIL bp_hold[%0d] got v=%b pc=%h inst=%h want 1/4/93", i, dec_valid, pc, inst); end
            tests++; if (mem_addr !== 32'd8 || fetch_cnt !== 32'd4) begin fails++; $display("FAIL bp_addr[%0d] got addr=%h cnt=%0d want 8/4", i, mem_addr, fetch_cnt); end
            step();
        end
    endtask

    task automatic test_redirect();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0043;
        dec_ready = 1'b1;
        step();
        redirect = 1'b0;
        tests++; if (dec_valid !== 1'b0 || fetch_cnt !== 32'd5) begin fails++; $display("FAIL redir_squash got v=%b cnt=%0d want 0/5", dec_valid, fetch_cnt); end
        tests++; if (mem_addr !== 32'h40) begin fails++; $display("FAIL redir_align got addr=%h want 40", mem_addr); end
        step();
        tests++; if (dec_valid !== 1'b1 || pc !== 32'h40) begin fails++; $display("FAIL redir_target got v=%b pc=%h want 1/40", dec_valid, pc); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL wrap_squash got v=%b want 0", dec_valid); end
        step();
        tests++; if (dec_valid !== 1'b1 || pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top got v=%b pc=%h want 1/fffffffc", dec_valid, pc); end
        step();
        tests++; if (pc !== 32'd0 || inst !== 32'h13 || fetch_cnt !== 32'd7) begin fails++; $display("FAIL wrap_zero got pc=%h inst=%h cnt=%0d want 0/13/7", pc, inst, fetch_cnt); end
        dec_ready = 1'b0;
    endtask

    task automatic test_halt();
        halt = 1'b1;
        step();
        tests++; if (state !== 2'd2 || dec_valid !== 1'b1 || pc !== 32'd0) begin fails++; $display("FAIL halt_enter got st=%0d v=%b pc=%h want 2/1/0", state, dec_valid, pc); end
        step();
        tests++; if (dec_valid !== 1'b1 || pc !== 32'd0 || inst !== 32'h13) begin fails++; $display("FAIL halt_hold got v=%b pc=%h inst=%h want 1/0/13", dec_valid, pc, inst); end
        dec_ready = 1'b1;
        step();
        tests++; if (dec_valid !== 1'b0 || fetch_cnt !== 32'd8) begin fails++; $display("FAIL halt_drain got v=%b cnt=%0d want 0/8", dec_valid, fetch_cnt); end
        step();
        step();
        tests++; if (dec_valid !== 1'b0 || state !== 2'd2) begin fails++; $display("FAIL halt_idle got v=%b st=%0d want 0/2", dec_valid, state); end
        start = 1'b1;
        step();
        tests++; if (state !== 2'd2) begin fails++; $display("FAIL halt_block got st=%0d want 2", state); end
        halt = 1'b0;
        step();
        start = 1'b0;
        tests++; if (state !== 2'd1 || dec_valid !== 1'b0) begin fails++; $display("FAIL resume got st=%0d v=%b want 1/0", state, dec_valid); end
        step();
        tests++; if (dec_valid !== 1'b1 || pc !== 32'd4 || inst !== 32'h93) begin fails++; $display("FAIL resume_pc got v=%b pc=%h inst=%h want 1/4/93", dec_valid, pc, inst); end
    endtask

    task automatic test_reset_mid_run();
        dec_ready = 1'b0;
        step();
        #2;
        rstn = 1'b0;
        #1;
        tests++; if (state !== 2'd0 || dec_valid !== 1'b0 || fetch_cnt !== 32'd0 || pc !== 32'd0) begin fails++; $display("FAIL midrst got st=%0d v=%b cnt=%0d pc=%h want 0/0/0/0", state, dec_valid, fetch_cnt, pc); end
        step();
        rstn = 1'b1;
        dec_ready = 1'b1;
        step();
        step();
        tests++; if (state !== 2'd0 || dec_valid !== 1'b0 || fetch_cnt !== 32'd0) begin fails++; $display("FAIL midrst_stay got st=%0d v=%b cnt=%0d want 0/0/0", state, dec_valid, fetch_cnt); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        rstn = 1'b0;
        start = 1'b0;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        load_valid = 1'b0;
        load_addr = 32'd0;
        load_data = 32'd0;
        dec_ready = 1'b0;
        test_reset();
        test_load();
        test_fetch();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after start from IDLE.
REQ-002 SHALL have port i_clk, input, 1, meaning the single clock; all flops on its rising edge.
REQ-003 SHALL have port i_rstn, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-004 SHALL have port i_start, input, 1, meaning a level request to begin or resume fetching.
REQ-005 SHALL have port i_halt, input, 1, meaning stop issuing fetches.
REQ-006 SHALL have port i_redirect, input, 1, meaning a branch/jump target is valid this cycle.
REQ-007 SHALL have port i_redirect_pc, input, 32, meaning the redirect target address.
REQ-008 SHALL have ports i_load_valid (input, 1), i_load_addr (input, 32), i_load_data (input, 32) and o_load_ready (output, 1), meaning the loader write channel.
REQ-009 SHALL have ports o_mem_we (output, 1), o_mem_addr (output, 32), o_mem_wdata (output, 32) and i_mem_rdata (input, 32), meaning the instruction-memory port; the memory read is combinational and word-indexed by addr[9:2].
REQ-010 SHALL have ports o_dec_valid (output, 1), i_dec_ready (input, 1), o_pc (output, 32) and o_inst (output, 32), meaning the decode-side handshake.
REQ-011 SHALL have port o_state, output, 2, meaning the FSM state (IDLE=0, RUN=1, HALT=2).
REQ-012 SHALL have port o_fetch_cnt, output, 32, meaning the count of accepted instructions.

Function
REQ-013 SHALL implement FSM transitions:
- IDLE->RUN on i_start & !i_load_valid.
- RUN->HALT on i_halt & !i_redirect.
- HALT->RUN on i_start & !i_halt.
- No other transitions.
REQ-014 SHALL drive o_load_ready=1 only in IDLE, with o_mem_we = i_load_valid & o_load_ready, o_mem_addr = i_load_addr and o_mem_wdata = i_load_data in that case; a load that coincides with i_start SHALL win, and start is deferred.
REQ-015 SHALL load pc_q = RESET_PC on the IDLE->RUN edge; in RUN, o_mem_addr = pc_q, o_mem_we = 0 and o_mem_wdata = 0.
REQ-016 SHALL define a fetch as: in RUN, !i_redirect and (!o_dec_valid | i_dec_ready); it registers o_pc <= pc_q, o_inst <= i_mem_rdata and o_dec_valid <= 1, and sets pc_q <= pc_q + 4.
REQ-017 SHALL give a fetch a latency of 1 cycle (first o_dec_valid in the cycle after RUN is entered) and a throughput of one instruction per cycle while i_dec_ready = 1.
REQ-018 SHALL keep o_pc, o_inst and o_dec_valid stable while o_dec_valid & !i_dec_ready (backpressure); pc_q SHALL NOT advance in that case.
REQ-019 SHALL give i_redirect (in RUN or HALT) priority over fetch and halt: pc_q <= {i_redirect_pc[31:2], 2'b00} and o_dec_valid <= 0 next cycle (squash), with no fetch in that cycle.
REQ-020 SHALL wrap pc_q from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
REQ-021 SHALL issue no new fetches in HALT; an already-valid output SHALL be held until accepted, then o_dec_valid <= 0.
REQ-022 SHALL increment o_fetch_cnt (mod 2^32) on every o_dec_valid & i_dec_ready cycle, in any state.
REQ-023 SHALL leave pc_q unchanged while in IDLE except on the IDLE->RUN edge.

Reset
REQ-024 SHALL, on !i_rstn asynchronously, set state=IDLE, pc_q=RESET_PC, o_pc=0, o_inst=0, o_dec_valid=0 and o_fetch_cnt=0; o_load_ready SHALL be 1 as a consequence of IDLE.
REQ-025 SHALL, on reset mid-RUN, drop any pending output (no acceptance counted) and require a new i_start to resume.

Structure
REQ-026 SHALL place the state encoding (IDLE/RUN/HALT) and the PC step constant 4 in the shared CPU package.
REQ-027 SHALL be a single module; the PC register is implemented inline, and the instruction memory remains external.

Verification
REQ-028 SHALL cover: in IDLE, load 3 words (0x13, 0x93, 0x113) at addresses 0, 4, 8 -> o_mem_we high for 3 cycles, o_load_ready=1.
REQ-029 SHALL cover: i_start with i_dec_ready=1 -> o_pc sequence 0, 4, 8 on consecutive cycles with o_inst 0x13, 0x93, 0x113, and o_fetch_cnt=3.
REQ-030 SHALL cover: i_dec_ready=0 for 4 cycles at o_pc=4 -> o_pc, o_inst and o_dec_valid constant, o_mem_addr stays 8.
REQ-031 SHALL cover: i_redirect with target 0x0000_0043 -> o_dec_valid=0 next cycle, then o_pc=0x40.
REQ-032 SHALL cover: redirect to 0xFFFF_FFFC -> o_pc sequence 0xFFFF_FFFC then 0x0.
REQ-033 SHALL cover: i_halt with the output stalled -> state=HALT, output held until accepted, then no further o_dec_valid; a later i_start resumes at the next pc_q.
